// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit frame controller: FSM states and line levels.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // A new frame may start from idle or directly out of the stop bit.
  function automatic logic can_accept(input state_t s);
    return (s == S_IDLE) || (s == S_STOP);
  endfunction

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity generator: even parity when PAR_TYP=0, odd when PAR_TYP=1.
module parity_calc
  import uart_tx_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic [Width-1:0] P_DATA,
  input  logic             PAR_TYP,
  output logic             par_bit
);

  assign par_bit = (^P_DATA) ^ PAR_TYP;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences start/data/parity/stop and drives the
// registered TX line, handing the data bits over to an external serializer.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [Width-1:0] P_DATA,
  input  logic             Data_Valid,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic             ser_data,
  input  logic             ser_done,
  output logic             ser_en,
  output logic             TX_OUT,
  output logic             busy
);

  state_t state_reg;
  logic   par_bit_reg;
  logic   par_en_reg;
  logic   tx_out_reg;
  logic   line_next;
  logic   par_bit_calc;
  logic   accept;

  parity_calc #(.Width(Width)) u_parity (
    .P_DATA  (P_DATA),
    .PAR_TYP (PAR_TYP),
    .par_bit (par_bit_calc)
  );

  assign accept = Data_Valid && can_accept(state_reg);

  always_comb begin
    line_next = LINE_IDLE;
    case (state_reg)
      S_IDLE:   line_next = LINE_IDLE;
      S_START:  line_next = START_BIT;
      S_DATA:   line_next = ser_data;
      S_PARITY: line_next = par_bit_reg;
      S_STOP:   line_next = STOP_BIT;
      default:  line_next = LINE_IDLE;
    endcase
  end

  // The parity type only matters through the latched parity bit, so it is folded in at accept.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg   <= S_IDLE;
      par_bit_reg <= 1'b0;
      par_en_reg  <= 1'b0;
      tx_out_reg  <= LINE_IDLE;
    end else begin
      tx_out_reg <= line_next;
      if (accept) begin
        par_bit_reg <= par_bit_calc;
        par_en_reg  <= PAR_EN;
      end
      case (state_reg)
        S_IDLE:   if (accept) state_reg <= S_START;
        S_START:  state_reg <= S_DATA;
        S_DATA:   if (ser_done) state_reg <= par_en_reg ? S_PARITY : S_STOP;
        S_PARITY: state_reg <= S_STOP;
        S_STOP:   state_reg <= accept ? S_START : S_IDLE;
        default:  state_reg <= S_IDLE;
      endcase
    end
  end

  assign TX_OUT = tx_out_reg;
  assign ser_en = (state_reg == S_DATA);
  assign busy   = (state_reg != S_IDLE);

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Frame controller and line driver for the UART transmitter.
- Accepts a parallel byte on Data_Valid and sequences the serial frame: start bit, Width data bits (LSB first), optional parity bit, stop bit.
- Drives the enable of the downstream bit serializer, consumes its ser_data/ser_done, and multiplexes start/data/parity/stop onto the registered TX_OUT line.
- Sits between the UART_TX top-level input interface and the physical TX pin.

Parameters:
- Width, 8, data bits per frame; P_DATA width and parity-calculation width.

Ports:
- CLK  input  1  transmit bit clock; one bit period per cycle.
- RST  input  1  asynchronous, active-low reset.
- P_DATA  input  Width  parallel data; sampled only on accept.
- Data_Valid  input  1  request to send P_DATA.
- PAR_EN  input  1  1 = parity bit included; sampled on accept.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on accept.
- ser_data  input  1  current data bit from the serializer.
- ser_done  input  1  high in the cycle in which the serializer presents the last data bit.
- ser_en  output  1  serializer advance enable.
- TX_OUT  output  1  serial line, idle high.
- busy  output  1  frame in progress.

Behaviour:
- Reset: state IDLE, TX_OUT=1, busy=0, ser_en=0, latched parity bit=0, latched PAR_EN/PAR_TYP=0. Reset mid-frame aborts immediately; the line returns to 1 asynchronously and no partial stop bit is sent.
- Accept: in IDLE or STOP, Data_Valid=1 at a CLK edge accepts. On acceptance:
  - the parity bit is latched as ^P_DATA XOR PAR_TYP;
  - PAR_EN and PAR_TYP are latched;
  - next state is START.
- Data_Valid is ignored in START, DATA and PARITY. It is never queued.
- FSM states (encoded in the package) and transitions:
  - IDLE -> START on accept, else stay in IDLE.
  - START -> DATA unconditionally; START lasts 1 cycle.
  - DATA: stays in DATA while ser_done=0. When ser_done=1, go to PARITY if latched PAR_EN=1, else to STOP.
  - PARITY -> STOP unconditionally; PARITY lasts 1 cycle.
  - STOP -> START on accept (back-to-back, no idle bit), else -> IDLE.
- Moore outputs, decoded from current state:
  - ser_en = (state==DATA).
  - busy = (state!=IDLE).
- Line mux (combinational select by state):
  - IDLE: 1.
  - START: 0.
  - DATA: ser_data.
  - PARITY: latched parity bit.
  - STOP: 1.
- TX_OUT is the mux output registered. Each bit therefore appears on TX_OUT one cycle after its state cycle.
- Latency:
  - Accept edge at cycle 0 gives START state in cycle 1 and TX_OUT=0 in cycle 2.
  - Frame length on the line is 1+Width+PAR_EN+1 cycles.
  - busy is high for exactly that many cycles, offset one cycle earlier than TX_OUT.
- ser_done outside DATA is ignored.
- If ser_done never arrives, the block remains in DATA. No timeout is applied; this is the serializer's contract.
- PAR_EN/PAR_TYP changes mid-frame have no effect on the current frame.
- P_DATA changes mid-frame have no effect on the parity bit. Data bits come from the serializer's own capture.

Decomposition:
- Package uart_tx_pkg:
  - state encoding constants S_IDLE, S_START, S_DATA, S_PARITY, S_STOP (3 bits);
  - line constants LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
- Sub-module parity_calc (Width param; inputs P_DATA, PAR_TYP; output par_bit), purely combinational, instantiated once. The FSM, latch registers and output mux stay in uart_tx_ctrl.

Test Plan:
- The bench uses a behavioural serializer model that captures P_DATA on accept, presents bit i in DATA cycle i, and pulses ser_done on bit Width-1.
- Scenario 1: P_DATA=0xA5, PAR_EN=0, single Data_Valid pulse -> TX_OUT from cycle 2 = 0,1,0,1,0,0,1,0,1,1 then stays 1; busy high 10 cycles; ser_en high 8 cycles.
- Scenario 2: 0xA5 with PAR_EN=1, PAR_TYP=0 -> parity bit 0, frame 11 bits. Same data with PAR_TYP=1 -> parity bit 1.
- Scenario 3: 0x07, even parity -> parity bit 1. Then change PAR_TYP and P_DATA during DATA -> parity bit unchanged.
- Scenario 4: Data_Valid held high continuously with 0x55 then 0x3C, no parity -> stop bit of frame 1 immediately followed by start bit of frame 2; no idle cycle. Additionally, Data_Valid pulses during START/DATA are dropped, so only 2 frames are emitted.
- Scenario 5: assert RST low during DATA bit 4 -> TX_OUT=1, busy=0, ser_en=0 asynchronously. After release, a fresh 0xC3 frame transmits correctly.
- Scenario 6: ser_done pulse injected in IDLE/START/STOP -> no state change; frame timing identical to Scenario 1.
